// File: rtl/spi_master_arbiter.sv
// Round-robin front end that shares one spi_master between N_REQ clients:
// latches the winner's word and mode, starts the master, and returns the response.
`timescale 1ns/1ps
module spi_master_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [2*N_REQ-1:0]     req_mode,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic [WIDTH-1:0]       m_din,
    output logic                   m_start,
    output logic [1:0]             m_mode,
    input  logic                   m_rdy,
    input  logic [WIDTH-1:0]       m_dout
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_next;
    logic [PTR_W-1:0] owner, owner_next;
    logic [WD_W-1:0]  wd, wd_next;
    logic [N_REQ-1:0] gnt_next, rsp_valid_next;
    logic             rsp_err_next, m_start_next, busy_next;
    logic [WIDTH-1:0] rsp_data_next, m_din_next;
    logic [1:0]       m_mode_next;

    logic [PTR_W-1:0] cand, win_idx;
    logic             win_found;
    logic [WIDTH-1:0] win_data;
    logic [1:0]       win_mode;

    // Cyclic search for the first pending request at or after rr_ptr.
    always_comb begin
        cand      = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
        win_data = req_data[int'(win_idx)*WIDTH +: WIDTH];
        win_mode = req_mode[int'(win_idx)*2 +: 2];
    end

    // Next-state and next values of every registered output.
    always_comb begin
        state_next     = state;
        rr_ptr_next    = rr_ptr;
        owner_next     = owner;
        wd_next        = wd;
        gnt_next       = '0;
        rsp_valid_next = '0;
        rsp_err_next   = 1'b0;
        m_start_next   = 1'b0;
        rsp_data_next  = rsp_data;
        m_din_next     = m_din;
        m_mode_next    = m_mode;

        case (state)
            IDLE: begin
                if (|req) begin
                    state_next   = START;
                    owner_next   = win_idx;
                    m_din_next   = win_data;
                    m_mode_next  = win_mode;
                    gnt_next     = N_REQ'(1) << win_idx;
                    m_start_next = 1'b1;
                end
            end
            START: begin
                state_next = BUSY;
                wd_next    = '0;
            end
            BUSY: begin
                if (m_rdy) begin
                    state_next     = DONE;
                    rsp_data_next  = m_dout;
                    rsp_valid_next = N_REQ'(1) << owner;
                end else if (wd == WD_W'(TIMEOUT - 1)) begin
                    state_next     = DONE;
                    rsp_valid_next = N_REQ'(1) << owner;
                    rsp_err_next   = 1'b1;
                end else begin
                    wd_next = wd + 1'b1;
                end
            end
            DONE: begin
                state_next  = IDLE;
                rr_ptr_next = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            wd        <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            m_din     <= '0;
            m_start   <= 1'b0;
            m_mode    <= '0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            owner     <= owner_next;
            wd        <= wd_next;
            gnt       <= gnt_next;
            rsp_valid <= rsp_valid_next;
            rsp_err   <= rsp_err_next;
            rsp_data  <= rsp_data_next;
            busy      <= busy_next;
            m_din     <= m_din_next;
            m_start   <= m_start_next;
            m_mode    <= m_mode_next;
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a loopback behavioural SPI master
// (the master returns the word it was given after a programmable latency).
`timescale 1ns/1ps
module tb_spi_master_arbiter;

    logic        clk, rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [7:0]  req_mode;
    logic [3:0]  gnt, rsp_valid;
    logic        rsp_err, busy, m_start, m_rdy;
    logic [7:0]  rsp_data, m_din, m_dout;
    logic [1:0]  m_mode;

    typedef struct {
        logic [3:0] oh;
        logic [7:0] data;
        logic [1:0] mode;
        logic       err;
    } exp_t;

    exp_t gnt_q[$];
    exp_t rsp_q[$];

    logic [7:0] data_tab [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};
    logic [1:0] mode_tab [4] = '{2'b00, 2'b11, 2'b01, 2'b10};

    int total = 0;
    int bad = 0;
    int gnt_seen = 0;

    logic [3:0] req_set = '0;
    logic [3:0] req_taken = '0;
    logic       auto_drop = 1'b1;
    logic       master_on = 1'b1;
    int         lat = 3;

    // A requester drops its bit once it has seen its grant.
    assign req = req_set & ~req_taken;

    spi_master_arbiter #(.N_REQ(4), .WIDTH(8), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .busy(busy), .m_din(m_din), .m_start(m_start), .m_mode(m_mode),
        .m_rdy(m_rdy), .m_dout(m_dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, required finish before 200us");
        $fatal(1, "[TB] run aborted");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic flagFail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("[TB] FAIL %s: got 0x%0h, required no such event", name, act);
    endtask

    task automatic checkResetOutputs(input string p);
        checkOutput({p, "_gnt"}, 32'(gnt), 32'h0);
        checkOutput({p, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        checkOutput({p, "_rsp_err"}, 32'(rsp_err), 32'h0);
        checkOutput({p, "_m_start"}, 32'(m_start), 32'h0);
        checkOutput({p, "_busy"}, 32'(busy), 32'h0);
        checkOutput({p, "_rsp_data"}, 32'(rsp_data), 32'h0);
        checkOutput({p, "_m_din"}, 32'(m_din), 32'h0);
        checkOutput({p, "_m_mode"}, 32'(m_mode), 32'h0);
    endtask

    task automatic expectGnt(input int idx);
        exp_t e;
        e.oh   = 4'b0001 << idx;
        e.data = data_tab[idx];
        e.mode = mode_tab[idx];
        e.err  = 1'b0;
        gnt_q.push_back(e);
    endtask

    task automatic expectXfer(input int idx, input logic [7:0] rd, input logic err);
        exp_t e;
        expectGnt(idx);
        e.oh   = 4'b0001 << idx;
        e.data = rd;
        e.mode = 2'b00;
        e.err  = err;
        rsp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        @(negedge clk);
        req_set = 4'b0000;
        repeat (2) @(negedge clk);
        req_set = r;
    endtask

    task automatic waitGntBit(input logic [1:0] idx, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (gnt[idx]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flagFail("gnt_wait", 32'(gnt));
    endtask

    task automatic waitIdle(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!busy && gnt_q.size() == 0 && rsp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) flagFail(name, 32'(rsp_q.size()));
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Behavioural master: captures m_din on m_start and echoes it back after lat cycles.
    initial begin : master_model
        int         cnt;
        logic       pend;
        logic [7:0] cap;
        m_rdy  = 1'b0;
        m_dout = 8'h00;
        pend   = 1'b0;
        cnt    = 0;
        cap    = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            m_rdy = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    m_rdy  = 1'b1;
                    m_dout = cap;
                    pend   = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (m_start && master_on) begin
                pend = 1'b1;
                cap  = m_din;
                cnt  = lat;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a response.
    initial begin : monitor
        exp_t e;
        logic rdy_prev;
        rdy_prev = 1'b0;
        forever begin
            @(negedge clk);
            req_taken = auto_drop ? ((req_taken | gnt) & req_set) : (req_taken & req_set);
            if (!rst_n) begin
                rdy_prev = 1'b0;
            end else begin
                if (m_start || gnt != 4'b0000) begin
                    if (gnt_q.size() == 0) begin
                        flagFail("gnt_unexpected", 32'(gnt));
                    end else begin
                        e = gnt_q.pop_front();
                        checkOutput("gnt_onehot", 32'(gnt), 32'(e.oh));
                        checkOutput("gnt_m_start", 32'(m_start), 32'h1);
                        checkOutput("gnt_m_din", 32'(m_din), 32'(e.data));
                        checkOutput("gnt_m_mode", 32'(m_mode), 32'(e.mode));
                        gnt_seen++;
                    end
                end
                if (rsp_valid != 4'b0000 || rsp_err) begin
                    if (rsp_q.size() == 0) begin
                        flagFail("rsp_unexpected", 32'(rsp_valid));
                    end else begin
                        e = rsp_q.pop_front();
                        checkOutput("rsp_valid", 32'(rsp_valid), 32'(e.oh));
                        checkOutput("rsp_data", 32'(rsp_data), 32'(e.data));
                        checkOutput("rsp_err", 32'(rsp_err), 32'(e.err));
                        checkOutput("rsp_busy", 32'(busy), 32'h1);
                        if (!e.err) checkOutput("rsp_latency", 32'(rdy_prev), 32'h1);
                    end
                end
                rdy_prev = m_rdy;
            end
        end
    end

    initial begin : stimulus
        bit ok;
        int n;
        int target;
        rst_n    = 1'b0;
        req_data = '0;
        req_mode = '0;
        for (int i = 0; i < 4; i++) begin
            req_data[i*8 +: 8] = data_tab[i];
            req_mode[i*2 +: 2] = mode_tab[i];
        end
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;

        // Single transfer from requester 0.
        expectXfer(0, 8'hA5, 1'b0);
        applyStimulus(4'b0001);
        @(negedge clk);
        checkOutput("req_to_gnt", 32'(gnt), 32'h1);
        checkOutput("single_mode", 32'(m_mode), 32'h0);
        waitIdle("single_done");

        // Fairness from a fresh pointer with all requests held.
        doReset();
        auto_drop = 1'b0;
        for (int i = 0; i < 8; i++) expectXfer(i % 4, data_tab[i % 4], 1'b0);
        target = gnt_seen + 8;
        applyStimulus(4'b1111);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (gnt_seen >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flagFail("fair_grants", 32'(gnt_seen));
        req_set = 4'b0000;
        waitIdle("fair_done");
        auto_drop = 1'b1;

        // Pointer wrap: serve 2, then 3 must beat 0.
        expectXfer(2, 8'h5A, 1'b0);
        applyStimulus(4'b0100);
        waitIdle("wrap_first");
        expectXfer(3, 8'hC3, 1'b0);
        expectXfer(0, 8'hA5, 1'b0);
        applyStimulus(4'b1001);
        waitIdle("wrap_done");

        // Mode and word must hold after the requester changes its inputs.
        expectXfer(1, 8'h3C, 1'b0);
        applyStimulus(4'b0010);
        waitGntBit(2'd1, ok);
        if (ok) begin
            checkOutput("mode_start", 32'(m_mode), 32'h3);
            req_mode[3:2]  = 2'b00;
            req_data[15:8] = 8'h00;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                checkOutput("mode_hold", 32'(m_mode), 32'h3);
                checkOutput("din_hold", 32'(m_din), 32'h3C);
                if (!busy) break;
            end
        end
        waitIdle("mode_done");

        // Watchdog abort: response 16 cycles after BUSY entry, data unchanged.
        master_on = 1'b0;
        expectXfer(2, 8'h3C, 1'b1);
        applyStimulus(4'b0100);
        waitGntBit(2'd2, ok);
        if (ok) begin
            n = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                n++;
                if (rsp_valid != 4'b0000) break;
            end
            checkOutput("timeout_latency", 32'(n), 32'd17);
            @(negedge clk);
            checkOutput("timeout_idle", 32'(busy), 32'h0);
        end
        waitIdle("timeout_done");
        master_on = 1'b1;

        // Reset while BUSY: everything clears and no response is issued.
        lat = 8;
        expectGnt(0);
        applyStimulus(4'b0001);
        waitGntBit(2'd0, ok);
        repeat (2) @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("abort");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lat = 3;
        expectXfer(0, 8'hA5, 1'b0);
        expectXfer(3, 8'hC3, 1'b0);
        applyStimulus(4'b1001);
        waitIdle("after_abort");
        req_set = 4'b0000;
        repeat (20) @(negedge clk);
        checkOutput("gnt_q_empty", 32'(gnt_q.size()), 32'd0);
        checkOutput("rsp_q_empty", 32'(rsp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
